alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequential initiator for the team's combinational ALU (2-bit opcode: add, sub, and, or; result plus zero flag). Accepts operation requests over a valid/ready interface and drives the ALU operand and opcode inputs from registers. After a settle interval it samples the ALU result and zero flag and returns them over a valid/ready response interface. It compares the sample against an internal golden model and keeps operation and mismatch counters, for in-system self-check of the ALU.

Parameters:
DATA_WIDTH, 5, operand/result width; must match the ALU instance
SETTLE_CYCLES, 1, cycles between driving ALU inputs and sampling its outputs; legal range >= 1
CNT_WIDTH, 8, width of op_count and mismatch_count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request ready; high only in IDLE
req_op1  in  DATA_WIDTH  operand 1
req_op2  in  DATA_WIDTH  operand 2
req_opcode  in  2  00 add, 01 sub, 10 and, 11 or
alu_rs1  out  DATA_WIDTH  registered operand 1 to ALU
alu_src2  out  DATA_WIDTH  registered operand 2 to ALU
alu_inst  out  2  registered opcode to ALU
alu_result  in  DATA_WIDTH  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_result  out  DATA_WIDTH  sampled ALU result
rsp_zero  out  1  sampled ALU zero flag
rsp_mismatch  out  1  sample differs from golden model
op_count  out  CNT_WIDTH  completed responses, saturating
mismatch_count  out  CNT_WIDTH  responses with rsp_mismatch=1, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; every output register is 0, including alu_*, rsp_*, and both counters. req_ready becomes 1 in IDLE after reset.
- FSM states: IDLE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid && req_ready at edge E0:
  - load alu_rs1/alu_src2/alu_inst from the request
  - load settle counter with SETTLE_CYCLES-1
  - go to SETTLE
- SETTLE: req_ready=0. Counter decrements each edge. At the edge where the counter is 0:
  - sample alu_result into rsp_result and alu_zero into rsp_zero
  - register rsp_mismatch
  - go to RESP
  - Net effect: sampling occurs at edge E0+SETTLE_CYCLES, and rsp_valid is high from that edge.
- RESP: rsp_valid=1. rsp_* are stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready:
  - increment op_count
  - increment mismatch_count if rsp_mismatch=1
  - clear rsp_valid and go to IDLE
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. Requests are never accepted outside IDLE.
- alu_* hold their last value until the next accepted request. They are not cleared after a response.
- Golden model, computed from the registered alu_* values:
  - add and sub are modulo 2^DATA_WIDTH; carry and borrow are discarded
  - and/or are bitwise
  - golden zero = (golden result == 0)
- rsp_mismatch = (alu_result != golden) || (alu_zero != golden zero).
- Counters saturate at all-ones and never wrap.
- Reset during SETTLE or RESP aborts the operation immediately. No response is produced and counters are cleared.
- req_* inputs are ignored outside the accept handshake.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11}
  - typedef enum seq_state_e {IDLE, SETTLE, RESP}
- Sub-module alu_golden_model: combinational, takes operands and opcode, returns result and zero. It is reused by future checkers.

Test Plan:
- Add 5+5 with the real ALU attached, rsp_ready=1 -> rsp_valid at acceptance edge +1; rsp_result=10, rsp_zero=0, rsp_mismatch=0, op_count=1.
- Sub 5-5 -> rsp_result=0, rsp_zero=1, rsp_mismatch=0.
- Wrap-around: add 31+1, then sub 0-1 (DATA_WIDTH=5) -> first gives rsp_result=0, rsp_zero=1; second gives rsp_result=31, rsp_zero=0; both mismatch=0.
- Fault injection: the bench forces alu_result=3 on AND 5&3 -> rsp_result=3, rsp_mismatch=1, mismatch_count=1.
- Backpressure: rsp_ready held low 4 cycles with req_valid=1 -> rsp_valid and rsp_* stable, req_ready=0. After rsp_ready, the next request is accepted 1 cycle later.
- SETTLE_CYCLES=3 with reset asserted in the second SETTLE cycle -> all outputs 0 immediately, no rsp_valid. With CNT_WIDTH=2, five ops saturate op_count at 3.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and sequencer state types
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } seq_state_e;

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational reference ALU used for self-check
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  alu_op_e               opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  // add/sub wrap modulo 2^DATA_WIDTH; carry and borrow are dropped
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives the ALU, samples after settle, checks against golden model
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 5,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0] req_op2,
  input  logic [1:0]            req_opcode,
  output logic [DATA_WIDTH-1:0] alu_rs1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  output logic [1:0]            alu_inst,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_mismatch,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [SCW-1:0]        settle_cnt;
  logic                  accept;
  logic                  sample;
  logic                  retire;
  logic [DATA_WIDTH-1:0] gold_result;
  logic                  gold_zero;

  alu_golden_model #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_golden (
    .op1   (alu_rs1),
    .op2   (alu_src2),
    .opcode(alu_op_e'(alu_inst)),
    .result(gold_result),
    .zero  (gold_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // alu_* deliberately hold after a response; only a new accept reloads them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rs1    <= '0;
      alu_src2   <= '0;
      alu_inst   <= '0;
      settle_cnt <= '0;
    end else if (accept) begin
      alu_rs1    <= req_op1;
      alu_src2   <= req_op2;
      alu_inst   <= req_opcode;
      settle_cnt <= SETTLE_LOAD;
    end else if (state_q == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else if (sample) begin
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
      rsp_mismatch <= (alu_result != gold_result) || (alu_zero != gold_zero);
    end
  end

  // Counters stick at all-ones so a long soak never reports a false low count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count       <= '0;
      mismatch_count <= '0;
    end else if (retire) begin
      if (op_count != CNT_MAX) op_count <= op_count + CNT_WIDTH'(1);
      if (rsp_mismatch && mismatch_count != CNT_MAX)
        mismatch_count <= mismatch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic       rst_n_a, rst_n_b;
  logic       req_valid_a, req_valid_b;
  logic [4:0] req_op1, req_op2;
  logic [1:0] req_opcode;
  logic       rsp_ready_a, rsp_ready_b;

  logic       req_ready_a, rsp_valid_a, rsp_zero_a, rsp_mismatch_a, alu_zero_a;
  logic [4:0] alu_rs1_a, alu_src2_a, rsp_result_a, alu_result_a;
  logic [1:0] alu_inst_a;
  logic [7:0] op_count_a, mismatch_count_a;

  logic       req_ready_b, rsp_valid_b, rsp_zero_b, rsp_mismatch_b, alu_zero_b;
  logic [4:0] alu_rs1_b, alu_src2_b, rsp_result_b, alu_result_b;
  logic [1:0] alu_inst_b;
  logic [1:0] op_count_b, mismatch_count_b;

  logic       force_en;
  logic [4:0] force_val;

  function automatic logic [4:0] alu_f(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Stand-in for the real ALU, with a fault-injection override on instance A
  always_comb begin
    alu_result_a = force_en ? force_val : alu_f(alu_rs1_a, alu_src2_a, alu_inst_a);
  end
  assign alu_zero_a   = (alu_result_a == 5'd0);
  assign alu_result_b = alu_f(alu_rs1_b, alu_src2_b, alu_inst_b);
  assign alu_zero_b   = (alu_result_b == 5'd0);

  alu_op_sequencer #(.DATA_WIDTH(5), .SETTLE_CYCLES(1), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .alu_rs1(alu_rs1_a), .alu_src2(alu_src2_a), .alu_inst(alu_inst_a),
    .alu_result(alu_result_a), .alu_zero(alu_zero_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_result(rsp_result_a), .rsp_zero(rsp_zero_a), .rsp_mismatch(rsp_mismatch_a),
    .op_count(op_count_a), .mismatch_count(mismatch_count_a)
  );

  alu_op_sequencer #(.DATA_WIDTH(5), .SETTLE_CYCLES(3), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .alu_rs1(alu_rs1_b), .alu_src2(alu_src2_b), .alu_inst(alu_inst_b),
    .alu_result(alu_result_b), .alu_zero(alu_zero_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_result(rsp_result_b), .rsp_zero(rsp_zero_b), .rsp_mismatch(rsp_mismatch_b),
    .op_count(op_count_b), .mismatch_count(mismatch_count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit use_b, input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] opc, input int lat, input logic [4:0] eres,
                        input logic ezero, input logic emm, input string tag);
    int cyc;
    req_op1 = a; req_op2 = b; req_opcode = opc;
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    cyc = 0;
    while (!(use_b ? req_ready_b : req_ready_a) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq({tag, "_req_ready"}, use_b ? req_ready_b : req_ready_a, 1);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    cyc = 0;
    while (!(use_b ? rsp_valid_b : rsp_valid_a) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq({tag, "_latency"}, cyc, lat);
    check_eq({tag, "_result"}, use_b ? rsp_result_b : rsp_result_a, eres);
    check_eq({tag, "_zero"}, use_b ? rsp_zero_b : rsp_zero_a, ezero);
    check_eq({tag, "_mismatch"}, use_b ? rsp_mismatch_b : rsp_mismatch_a, emm);
    if (use_b) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    check_eq({tag, "_rsp_drop"}, use_b ? rsp_valid_b : rsp_valid_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    req_op1 = '0; req_op2 = '0; req_opcode = '0;
    force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", rsp_valid_a, 0);
    check_eq("rst_alu_rs1", alu_rs1_a, 0);
    check_eq("rst_rsp_result", rsp_result_a, 0);
    check_eq("rst_op_count", op_count_a, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_req_ready", req_ready_a, 1);

    run_op(0, 5'd5, 5'd5, 2'b00, 1, 5'd10, 1'b0, 1'b0, "add_5_5");
    check_eq("add_op_count", op_count_a, 1);
    run_op(0, 5'd5, 5'd5, 2'b01, 1, 5'd0, 1'b1, 1'b0, "sub_5_5");
    run_op(0, 5'd31, 5'd1, 2'b00, 1, 5'd0, 1'b1, 1'b0, "add_wrap");
    run_op(0, 5'd0, 5'd1, 2'b01, 1, 5'd31, 1'b0, 1'b0, "sub_wrap");

    force_en = 1'b1; force_val = 5'd3;
    run_op(0, 5'd5, 5'd3, 2'b10, 1, 5'd3, 1'b0, 1'b1, "and_fault");
    force_en = 1'b0;
    check_eq("fault_mismatch_count", mismatch_count_a, 1);
    check_eq("fault_op_count", op_count_a, 5);
    check_eq("alu_inst_held", alu_inst_a, 2);
    check_eq("alu_rs1_held", alu_rs1_a, 5);

    // Backpressure: next request waits while the OR response is stalled
    req_op1 = 5'd5; req_op2 = 5'd8; req_opcode = 2'b11; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_op1 = 5'd9; req_op2 = 5'd6; req_opcode = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_rsp_valid", rsp_valid_a, 1);
      check_eq("bp_rsp_result", rsp_result_a, 13);
      check_eq("bp_req_ready", req_ready_a, 0);
      check_eq("bp_alu_rs1", alu_rs1_a, 5);
      @(posedge clk); #1;
    end
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    check_eq("bp_idle_ready", req_ready_a, 1);
    check_eq("bp_op_count", op_count_a, 6);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check_eq("bp_next_accepted", req_ready_a, 0);
    check_eq("bp_next_rs1", alu_rs1_a, 9);
    @(posedge clk); #1;
    check_eq("bp_next_valid", rsp_valid_a, 1);
    check_eq("bp_next_result", rsp_result_a, 15);
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    check_eq("bp_final_op_count", op_count_a, 7);

    // SETTLE_CYCLES=3 instance
    run_op(1, 5'd7, 5'd2, 2'b00, 3, 5'd9, 1'b0, 1'b0, "b_add");
    check_eq("b_op_count", op_count_b, 1);
    req_op1 = 5'd4; req_op2 = 5'd1; req_opcode = 2'b11; req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(posedge clk); #1;
    rst_n_b = 1'b0;
    #1;
    check_eq("abort_rsp_valid", rsp_valid_b, 0);
    check_eq("abort_alu_rs1", alu_rs1_b, 0);
    check_eq("abort_alu_inst", alu_inst_b, 0);
    check_eq("abort_op_count", op_count_b, 0);
    check_eq("abort_rsp_result", rsp_result_b, 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid_b) seen++;
    end
    check_eq("abort_no_rsp", seen, 0);
    rst_n_b = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_req_ready", req_ready_b, 1);

    for (int i = 0; i < 5; i++) begin
      run_op(1, 5'(i), 5'd1, 2'b00, 3, 5'(i + 1), 1'b0, 1'b0, "b_sat");
      check_eq("sat_op_count", op_count_b, (i + 1 > 3) ? 3 : i + 1);
    end
    check_eq("sat_mismatch_count", mismatch_count_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
